// File: rtl/mag_stream_to_bram_pkg.sv
// Shared definitions for the magnitude-stream histogram writer.
// Holds the default widths, the FFT frame length and the frame-sync FSM
// state encoding used by the top level and its peak tracker.
package mag_stream_to_bram_pkg;

  localparam int IDX_W     = 12;    // FFT bin index width (4096-point frame)
  localparam int ADDR_W    = 10;    // stored bins = 2**ADDR_W
  localparam int DATA_W    = 16;    // stored magnitude width
  localparam int MAG_W     = 24;    // incoming magnitude width
  localparam int FRAME_LEN = 4096;  // beats per complete FFT frame

  typedef enum logic [0:0] {
    ST_SYNC = 1'b0,  // hunting for a bin-0 beat
    ST_RUN  = 1'b1   // inside a frame, checking index continuity
  } state_e;

endpackage

// File: rtl/mag_stream_to_bram_if.sv
// AXI-stream style magnitude channel from the FFT magnitude stage.
//   s_tdata  : magnitude, MAG_W bits
//   s_tuser  : FFT bin index, IDX_W bits
//   s_tlast  : frame end marker
//   s_tvalid : beat valid
//   s_tready : sink ready
// master drives the beat fields, slave returns s_tready.
interface mag_stream_to_bram_if #(
  parameter int MAG_W = mag_stream_to_bram_pkg::MAG_W,
  parameter int IDX_W = mag_stream_to_bram_pkg::IDX_W
);

  logic [MAG_W-1:0] s_tdata;
  logic [IDX_W-1:0] s_tuser;
  logic             s_tlast;
  logic             s_tvalid;
  logic             s_tready;

  modport master (
    output s_tdata, s_tuser, s_tlast, s_tvalid,
    input  s_tready
  );

  modport slave (
    input  s_tdata, s_tuser, s_tlast, s_tvalid,
    output s_tready
  );

endinterface

// File: rtl/mag_stream_to_bram_bin_peak_tracker.sv
// Running maximum over the bins written during one frame.
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : restart the search (takes effect after this edge)
//   smp_valid    : a bin is being sampled this cycle
//   smp_bin      : bin number of the sample
//   smp_mag      : stored magnitude of the sample
//   peak_bin     : best bin so far, including this cycle's sample
//   peak_mag     : magnitude of peak_bin
// The outputs already fold in the current sample so a consumer that
// registers them on the closing edge of a frame sees the full result,
// and clear only zeroes the state behind them, so the outgoing frame's
// peak is still readable in the same cycle a new frame starts.
module bin_peak_tracker #(
  parameter int ADDR_W = mag_stream_to_bram_pkg::ADDR_W,
  parameter int DATA_W = mag_stream_to_bram_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              smp_valid,
  input  logic [ADDR_W-1:0] smp_bin,
  input  logic [DATA_W-1:0] smp_mag,
  output logic [ADDR_W-1:0] peak_bin,
  output logic [DATA_W-1:0] peak_mag
);

  import mag_stream_to_bram_pkg::*;

  logic [ADDR_W-1:0] bin_q, bin_d;
  logic [DATA_W-1:0] mag_q, mag_d;

  always_comb begin
    peak_bin = bin_q;
    peak_mag = mag_q;
    // strict compare: on a tie the earlier (lower) bin is kept
    if (smp_valid && (smp_mag > mag_q)) begin
      peak_bin = smp_bin;
      peak_mag = smp_mag;
    end
    bin_d = clear ? '0 : peak_bin;
    mag_d = clear ? '0 : peak_mag;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bin_q <= '0;
      mag_q <= '0;
    end else begin
      bin_q <= bin_d;
      mag_q <= mag_d;
    end
  end

endmodule

// File: rtl/mag_stream_to_bram.sv
// Writes one FFT frame of magnitudes into a double-buffered histogram
// BRAM and publishes the frame's peak bin when the frame completes.
//   clk, reset_n     : clock, asynchronous active-low reset
//   enable           : accept the stream when high
//   s                : magnitude stream (slave side, never backpressures)
//   wr_en/addr/data  : BRAM port A, wr_addr = {bank, bin}
//   rd_bank          : bank the display reader owns
//   frame_done       : one-cycle pulse per completed frame
//   frame_count      : completed frames, wraps
//   peak_bin/mag     : largest non-DC bin of the last completed frame
//   err_*            : one-cycle protocol error pulses
module mag_stream_to_bram #(
  parameter int IDX_W  = mag_stream_to_bram_pkg::IDX_W,
  parameter int ADDR_W = mag_stream_to_bram_pkg::ADDR_W,
  parameter int DATA_W = mag_stream_to_bram_pkg::DATA_W,
  parameter int MAG_W  = mag_stream_to_bram_pkg::MAG_W
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  mag_stream_to_bram_if.slave     s,
  output logic                    wr_en,
  output logic [ADDR_W:0]         wr_addr,
  output logic [DATA_W-1:0]       wr_data,
  output logic                    rd_bank,
  output logic                    frame_done,
  output logic [15:0]             frame_count,
  output logic [ADDR_W-1:0]       peak_bin,
  output logic [DATA_W-1:0]       peak_mag,
  output logic                    err_index,
  output logic                    err_early_last,
  output logic                    err_missing_last
);

  import mag_stream_to_bram_pkg::*;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  function automatic logic [DATA_W-1:0] sat_mag(input logic [MAG_W-1:0] m);
    return (m[MAG_W-1:DATA_W] == '0) ? m[DATA_W-1:0] : '1;
  endfunction

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  exp_q, exp_d;
  logic              rdy_q, rdy_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              err_idx_q, err_idx_d;
  logic              err_early_q, err_early_d;
  logic              err_miss_q, err_miss_d;
  logic              done1_q, done1_d;
  logic              frame_done_q, frame_done_d;
  logic              rd_bank_q, rd_bank_d;
  logic [15:0]       fcount_q, fcount_d;
  logic [ADDR_W-1:0] peak_bin_q, peak_bin_d;
  logic [DATA_W-1:0] peak_mag_q, peak_mag_d;

  logic              accept;
  logic              in_range;
  logic              wr_bank;
  logic              wr_beat;
  logic              clr_peak;
  logic [ADDR_W-1:0] trk_bin;
  logic [DATA_W-1:0] trk_mag;

  bin_peak_tracker #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_peak (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clr_peak),
    .smp_valid (wr_en_q && (wr_addr_q[ADDR_W-1:0] != '0)),
    .smp_bin   (wr_addr_q[ADDR_W-1:0]),
    .smp_mag   (wr_data_q),
    .peak_bin  (trk_bin),
    .peak_mag  (trk_mag)
  );

  always_comb begin
    accept   = s.s_tvalid & rdy_q;
    in_range = (s.s_tuser[IDX_W-1:ADDR_W] == '0);
    // The bank swap lands one cycle after the completing beat's write,
    // so a back-to-back frame starting in that gap cycle must already
    // target the bank that is about to be released by the reader.
    wr_bank  = ~(rd_bank_q ^ done1_q);

    state_d     = state_q;
    exp_d       = exp_q;
    rdy_d       = enable;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    err_idx_d   = 1'b0;
    err_early_d = 1'b0;
    err_miss_d  = 1'b0;
    done1_d     = 1'b0;
    wr_beat     = 1'b0;
    clr_peak    = 1'b0;

    // stage 0: frame sync and index checking on the accepted beat
    case (state_q)
      ST_SYNC: begin
        if (accept && (s.s_tuser == '0)) begin
          state_d  = ST_RUN;
          exp_d    = IDX_W'(1);
          clr_peak = 1'b1;
          wr_beat  = 1'b1;
        end
      end
      ST_RUN: begin
        if (!rdy_q) begin
          // enable dropped: quiet abort, the frame is simply not used
          state_d = ST_SYNC;
        end else if (accept) begin
          if (s.s_tuser != exp_q) begin
            err_idx_d = 1'b1;
            state_d   = ST_SYNC;
          end else if (s.s_tuser == LAST_IDX) begin
            wr_beat    = 1'b1;
            done1_d    = 1'b1;
            err_miss_d = ~s.s_tlast;
            state_d    = ST_SYNC;
          end else if (s.s_tlast) begin
            err_early_d = 1'b1;
            state_d     = ST_SYNC;
          end else begin
            wr_beat = 1'b1;
            exp_d   = exp_q + IDX_W'(1);
          end
        end
      end
      default: state_d = ST_SYNC;
    endcase

    if (wr_beat && in_range) begin
      wr_en_d   = 1'b1;
      wr_addr_d = {wr_bank, s.s_tuser[ADDR_W-1:0]};
      wr_data_d = sat_mag(s.s_tdata);
    end

    // stage 1 -> 2: publish the completed frame
    frame_done_d = done1_q;
    rd_bank_d    = rd_bank_q ^ done1_q;
    fcount_d     = done1_q ? (fcount_q + 16'd1) : fcount_q;
    peak_bin_d   = done1_q ? trk_bin : peak_bin_q;
    peak_mag_d   = done1_q ? trk_mag : peak_mag_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_SYNC;
      exp_q        <= '0;
      rdy_q        <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      err_idx_q    <= 1'b0;
      err_early_q  <= 1'b0;
      err_miss_q   <= 1'b0;
      done1_q      <= 1'b0;
      frame_done_q <= 1'b0;
      rd_bank_q    <= 1'b0;
      fcount_q     <= '0;
      peak_bin_q   <= '0;
      peak_mag_q   <= '0;
    end else begin
      state_q      <= state_d;
      exp_q        <= exp_d;
      rdy_q        <= rdy_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      err_idx_q    <= err_idx_d;
      err_early_q  <= err_early_d;
      err_miss_q   <= err_miss_d;
      done1_q      <= done1_d;
      frame_done_q <= frame_done_d;
      rd_bank_q    <= rd_bank_d;
      fcount_q     <= fcount_d;
      peak_bin_q   <= peak_bin_d;
      peak_mag_q   <= peak_mag_d;
    end
  end

  assign s.s_tready       = rdy_q;
  assign wr_en            = wr_en_q;
  assign wr_addr          = wr_addr_q;
  assign wr_data          = wr_data_q;
  assign rd_bank          = rd_bank_q;
  assign frame_done       = frame_done_q;
  assign frame_count      = fcount_q;
  assign peak_bin         = peak_bin_q;
  assign peak_mag         = peak_mag_q;
  assign err_index        = err_idx_q;
  assign err_early_last   = err_early_q;
  assign err_missing_last = err_miss_q;

endmodule

// File: tb/tb_mag_stream_to_bram.sv
module tb_mag_stream_to_bram;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [15:0] wr_data;
  logic        rd_bank;
  logic        frame_done;
  logic [15:0] frame_count;
  logic [9:0]  peak_bin;
  logic [15:0] peak_mag;
  logic        err_index, err_early_last, err_missing_last;

  int checks = 0;
  int failures = 0;

  // monitor counters (written only by the monitor)
  int wr_cnt = 0, bank1_cnt = 0, done_cnt = 0, ei_cnt = 0, ee_cnt = 0, em_cnt = 0;
  logic [15:0] mem [0:2047];

  // snapshots (written only by the stimulus process)
  int b_wr, b_b1, b_done, b_ei, b_ee, b_em;

  mag_stream_to_bram_if #(.MAG_W(24), .IDX_W(12)) s_if ();

  mag_stream_to_bram dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .enable           (enable),
    .s                (s_if),
    .wr_en            (wr_en),
    .wr_addr          (wr_addr),
    .wr_data          (wr_data),
    .rd_bank          (rd_bank),
    .frame_done       (frame_done),
    .frame_count      (frame_count),
    .peak_bin         (peak_bin),
    .peak_mag         (peak_mag),
    .err_index        (err_index),
    .err_early_last   (err_early_last),
    .err_missing_last (err_missing_last)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wr_cnt <= wr_cnt + 1;
      if (wr_addr[10]) bank1_cnt <= bank1_cnt + 1;
      mem[wr_addr] <= wr_data;
    end
    if (frame_done === 1'b1)       done_cnt <= done_cnt + 1;
    if (err_index === 1'b1)        ei_cnt <= ei_cnt + 1;
    if (err_early_last === 1'b1)   ee_cnt <= ee_cnt + 1;
    if (err_missing_last === 1'b1) em_cnt <= em_cnt + 1;
  end

  task automatic snap();
    b_wr = wr_cnt; b_b1 = bank1_cnt; b_done = done_cnt;
    b_ei = ei_cnt; b_ee = ee_cnt; b_em = em_cnt;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      s_if.s_tvalid = 1'b0;
      s_if.s_tlast  = 1'b0;
    end
  endtask

  // beats first..last_i (skipping skip_i), mag = bin*3 except sat_i
  task automatic run_frame(input int first, input int last_i, input int skip_i,
                           input int tlast_i, input int sat_i);
    for (int i = first; i <= last_i; i++) begin
      if (i == skip_i) continue;
      @(negedge clk);
      s_if.s_tvalid = 1'b1;
      s_if.s_tuser  = 12'(i);
      s_if.s_tdata  = (i == sat_i) ? 24'h012345 : 24'(i * 3);
      s_if.s_tlast  = (i == tlast_i);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0;
    s_if.s_tvalid = 1'b0; s_if.s_tuser = '0; s_if.s_tdata = '0; s_if.s_tlast = 1'b0;
    #12;
    checks++; if (s_if.s_tready !== 1'b0) begin failures++; $display("FAIL rst_tready got=%0h exp=0", s_if.s_tready); end
    checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL rst_wr_en got=%0h exp=0", wr_en); end
    checks++; if (wr_addr !== 11'd0) begin failures++; $display("FAIL rst_wr_addr got=%0h exp=0", wr_addr); end
    checks++; if (wr_data !== 16'd0) begin failures++; $display("FAIL rst_wr_data got=%0h exp=0", wr_data); end
    checks++; if (rd_bank !== 1'b0) begin failures++; $display("FAIL rst_rd_bank got=%0h exp=0", rd_bank); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL rst_frame_done got=%0h exp=0", frame_done); end
    checks++; if (frame_count !== 16'd0) begin failures++; $display("FAIL rst_frame_count got=%0h exp=0", frame_count); end
    checks++; if ({peak_bin, peak_mag} !== 26'd0) begin failures++; $display("FAIL rst_peak got=%0h/%0h exp=0/0", peak_bin, peak_mag); end
    checks++; if ({err_index, err_early_last, err_missing_last} !== 3'b000) begin failures++; $display("FAIL rst_errs got=%b exp=000", {err_index, err_early_last, err_missing_last}); end
    @(negedge clk);
    reset_n = 1'b1; enable = 1'b1;
    idle(2);
    checks++; if (s_if.s_tready !== 1'b1) begin failures++; $display("FAIL en_tready got=%0h exp=1", s_if.s_tready); end
  endtask

  task automatic test_full_frame();
    snap();
    run_frame(0, 0, -1, -1, -1);
    #1;
    checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL full_wr_pre got=%0h exp=0", wr_en); end
    @(posedge clk); #2;
    checks++; if (wr_en !== 1'b1) begin failures++; $display("FAIL full_wr_lat got=%0h exp=1", wr_en); end
    checks++; if (wr_addr !== 11'h400) begin failures++; $display("FAIL full_wr_addr0 got=%0h exp=400", wr_addr); end
    run_frame(1, 4095, -1, 4095, -1);
    @(posedge clk); #2;
    s_if.s_tvalid = 1'b0;
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL full_done_n1 got=%0h exp=0", frame_done); end
    checks++; if (rd_bank !== 1'b0) begin failures++; $display("FAIL full_bank_n1 got=%0h exp=0", rd_bank); end
    @(posedge clk); #2;
    checks++; if (frame_done !== 1'b1) begin failures++; $display("FAIL full_done_n2 got=%0h exp=1", frame_done); end
    checks++; if (rd_bank !== 1'b1) begin failures++; $display("FAIL full_bank_n2 got=%0h exp=1", rd_bank); end
    checks++; if (peak_bin !== 10'd1023) begin failures++; $display("FAIL full_peak_bin got=%0d exp=1023", peak_bin); end
    checks++; if (peak_mag !== 16'd3069) begin failures++; $display("FAIL full_peak_mag got=%0d exp=3069", peak_mag); end
    checks++; if (frame_count !== 16'd1) begin failures++; $display("FAIL full_count got=%0d exp=1", frame_count); end
    @(posedge clk); #2;
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL full_done_n3 got=%0h exp=0", frame_done); end
    idle(2);
    checks++; if (wr_cnt - b_wr !== 1024) begin failures++; $display("FAIL full_writes got=%0d exp=1024", wr_cnt - b_wr); end
    checks++; if (bank1_cnt - b_b1 !== 1024) begin failures++; $display("FAIL full_bank1_writes got=%0d exp=1024", bank1_cnt - b_b1); end
    checks++; if (mem[11'h405] !== 16'd15) begin failures++; $display("FAIL full_mem5 got=%0d exp=15", mem[11'h405]); end
    checks++; if (mem[11'h7FF] !== 16'd3069) begin failures++; $display("FAIL full_mem1023 got=%0d exp=3069", mem[11'h7FF]); end
    checks++; if (ei_cnt + ee_cnt + em_cnt - b_ei - b_ee - b_em !== 0) begin failures++; $display("FAIL full_errs got=%0d exp=0", ei_cnt + ee_cnt + em_cnt - b_ei - b_ee - b_em); end
  endtask

  task automatic test_saturate();
    snap();
    run_frame(0, 4095, -1, 4095, 7);
    idle(4);
    checks++; if (mem[11'd7] !== 16'hFFFF) begin failures++; $display("FAIL sat_mem7 got=%0h exp=ffff", mem[11'd7]); end
    checks++; if (mem[11'd8] !== 16'd24) begin failures++; $display("FAIL sat_mem8 got=%0d exp=24", mem[11'd8]); end
    checks++; if (peak_bin !== 10'd7) begin failures++; $display("FAIL sat_peak_bin got=%0d exp=7", peak_bin); end
    checks++; if (peak_mag !== 16'hFFFF) begin failures++; $display("FAIL sat_peak_mag got=%0h exp=ffff", peak_mag); end
    checks++; if (rd_bank !== 1'b0) begin failures++; $display("FAIL sat_bank got=%0h exp=0", rd_bank); end
    checks++; if (frame_count !== 16'd2) begin failures++; $display("FAIL sat_count got=%0d exp=2", frame_count); end
  endtask

  task automatic test_midstart();
    snap();
    run_frame(100, 4095, -1, 4095, -1);
    idle(3);
    checks++; if (wr_cnt - b_wr !== 0) begin failures++; $display("FAIL mid_writes got=%0d exp=0", wr_cnt - b_wr); end
    checks++; if (done_cnt - b_done !== 0) begin failures++; $display("FAIL mid_done got=%0d exp=0", done_cnt - b_done); end
    checks++; if (ei_cnt + ee_cnt + em_cnt - b_ei - b_ee - b_em !== 0) begin failures++; $display("FAIL mid_errs got=%0d exp=0", ei_cnt + ee_cnt + em_cnt - b_ei - b_ee - b_em); end
    run_frame(0, 4095, -1, 4095, -1);
    idle(4);
    checks++; if (wr_cnt - b_wr !== 1024) begin failures++; $display("FAIL mid_frame_writes got=%0d exp=1024", wr_cnt - b_wr); end
    checks++; if (frame_count !== 16'd3) begin failures++; $display("FAIL mid_count got=%0d exp=3", frame_count); end
    checks++; if (rd_bank !== 1'b1) begin failures++; $display("FAIL mid_bank got=%0h exp=1", rd_bank); end
    checks++; if (peak_bin !== 10'd1023) begin failures++; $display("FAIL mid_peak_bin got=%0d exp=1023", peak_bin); end
  endtask

  task automatic test_skip_index();
    snap();
    run_frame(0, 4095, 500, 4095, -1);
    idle(4);
    checks++; if (ei_cnt - b_ei !== 1) begin failures++; $display("FAIL skip_err_index got=%0d exp=1", ei_cnt - b_ei); end
    checks++; if (done_cnt - b_done !== 0) begin failures++; $display("FAIL skip_done got=%0d exp=0", done_cnt - b_done); end
    checks++; if (rd_bank !== 1'b1) begin failures++; $display("FAIL skip_bank got=%0h exp=1", rd_bank); end
    checks++; if (frame_count !== 16'd3) begin failures++; $display("FAIL skip_count got=%0d exp=3", frame_count); end
    checks++; if (wr_cnt - b_wr !== 500) begin failures++; $display("FAIL skip_writes got=%0d exp=500", wr_cnt - b_wr); end
    snap();
    run_frame(0, 4095, -1, 4095, -1);
    idle(4);
    checks++; if (done_cnt - b_done !== 1) begin failures++; $display("FAIL skip_next_done got=%0d exp=1", done_cnt - b_done); end
    checks++; if (frame_count !== 16'd4) begin failures++; $display("FAIL skip_next_count got=%0d exp=4", frame_count); end
    checks++; if (rd_bank !== 1'b0) begin failures++; $display("FAIL skip_next_bank got=%0h exp=0", rd_bank); end
  endtask

  task automatic test_early_last();
    snap();
    run_frame(0, 2000, -1, 2000, -1);
    idle(4);
    checks++; if (ee_cnt - b_ee !== 1) begin failures++; $display("FAIL early_err got=%0d exp=1", ee_cnt - b_ee); end
    checks++; if (ei_cnt - b_ei !== 0) begin failures++; $display("FAIL early_err_index got=%0d exp=0", ei_cnt - b_ei); end
    checks++; if (done_cnt - b_done !== 0) begin failures++; $display("FAIL early_done got=%0d exp=0", done_cnt - b_done); end
    checks++; if (rd_bank !== 1'b0) begin failures++; $display("FAIL early_bank got=%0h exp=0", rd_bank); end
    checks++; if (frame_count !== 16'd4) begin failures++; $display("FAIL early_count got=%0d exp=4", frame_count); end
  endtask

  task automatic test_missing_last();
    snap();
    run_frame(0, 4095, -1, -1, -1);
    idle(4);
    checks++; if (em_cnt - b_em !== 1) begin failures++; $display("FAIL miss_err got=%0d exp=1", em_cnt - b_em); end
    checks++; if (done_cnt - b_done !== 1) begin failures++; $display("FAIL miss_done got=%0d exp=1", done_cnt - b_done); end
    checks++; if (rd_bank !== 1'b1) begin failures++; $display("FAIL miss_bank got=%0h exp=1", rd_bank); end
    checks++; if (frame_count !== 16'd5) begin failures++; $display("FAIL miss_count got=%0d exp=5", frame_count); end
  endtask

  task automatic test_back_to_back();
    snap();
    run_frame(0, 4095, -1, 4095, -1);
    run_frame(0, 4095, -1, 4095, -1);
    idle(4);
    checks++; if (done_cnt - b_done !== 2) begin failures++; $display("FAIL b2b_done got=%0d exp=2", done_cnt - b_done); end
    checks++; if (wr_cnt - b_wr !== 2048) begin failures++; $display("FAIL b2b_writes got=%0d exp=2048", wr_cnt - b_wr); end
    checks++; if (bank1_cnt - b_b1 !== 1024) begin failures++; $display("FAIL b2b_bank1_writes got=%0d exp=1024", bank1_cnt - b_b1); end
    checks++; if (rd_bank !== 1'b1) begin failures++; $display("FAIL b2b_bank got=%0h exp=1", rd_bank); end
    checks++; if (frame_count !== 16'd7) begin failures++; $display("FAIL b2b_count got=%0d exp=7", frame_count); end
    checks++; if (peak_mag !== 16'd3069) begin failures++; $display("FAIL b2b_peak_mag got=%0d exp=3069", peak_mag); end
  endtask

  task automatic test_enable_drop();
    snap();
    run_frame(0, 99, -1, -1, -1);
    @(negedge clk);
    s_if.s_tvalid = 1'b0;
    enable = 1'b0;
    idle(3);
    checks++; if (s_if.s_tready !== 1'b0) begin failures++; $display("FAIL endrop_tready got=%0h exp=0", s_if.s_tready); end
    enable = 1'b1;
    idle(2);
    run_frame(100, 4095, -1, 4095, -1);
    idle(4);
    checks++; if (wr_cnt - b_wr !== 100) begin failures++; $display("FAIL endrop_writes got=%0d exp=100", wr_cnt - b_wr); end
    checks++; if (ei_cnt + ee_cnt + em_cnt - b_ei - b_ee - b_em !== 0) begin failures++; $display("FAIL endrop_errs got=%0d exp=0", ei_cnt + ee_cnt + em_cnt - b_ei - b_ee - b_em); end
    checks++; if (done_cnt - b_done !== 0) begin failures++; $display("FAIL endrop_done got=%0d exp=0", done_cnt - b_done); end
    checks++; if (frame_count !== 16'd7) begin failures++; $display("FAIL endrop_count got=%0d exp=7", frame_count); end
  endtask

  task automatic test_reset_mid_frame();
    run_frame(0, 3000, -1, -1, -1);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    checks++; if (s_if.s_tready !== 1'b0) begin failures++; $display("FAIL rmid_tready got=%0h exp=0", s_if.s_tready); end
    checks++; if ({wr_en, wr_addr, wr_data} !== 28'd0) begin failures++; $display("FAIL rmid_wr got=%0h/%0h/%0h exp=0/0/0", wr_en, wr_addr, wr_data); end
    checks++; if (rd_bank !== 1'b0) begin failures++; $display("FAIL rmid_bank got=%0h exp=0", rd_bank); end
    checks++; if (frame_count !== 16'd0) begin failures++; $display("FAIL rmid_count got=%0d exp=0", frame_count); end
    checks++; if ({peak_bin, peak_mag} !== 26'd0) begin failures++; $display("FAIL rmid_peak got=%0h/%0h exp=0/0", peak_bin, peak_mag); end
    @(negedge clk);
    reset_n = 1'b1;
    snap();
    run_frame(3001, 4095, -1, 4095, -1);
    idle(4);
    checks++; if (wr_cnt - b_wr !== 0) begin failures++; $display("FAIL rmid_writes got=%0d exp=0", wr_cnt - b_wr); end
    checks++; if (done_cnt - b_done !== 0) begin failures++; $display("FAIL rmid_done got=%0d exp=0", done_cnt - b_done); end
    checks++; if (frame_count !== 16'd0) begin failures++; $display("FAIL rmid_count_after got=%0d exp=0", frame_count); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_saturate();
    test_midstart();
    test_skip_index();
    test_early_last();
    test_missing_last();
    test_back_to_back();
    test_enable_drop();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mag_stream_to_bram.md
MAG_STREAM_TO_BRAM -- requirements
Module: mag_stream_to_bram

Interface
REQ-001 SHALL have parameter IDX_W, default 12, meaning FFT bin index width on s_tuser (4096-point frame).
REQ-002 SHALL have parameter ADDR_W, default 10, meaning the number of stored bins is 2**ADDR_W (bins 0..1023).
REQ-003 SHALL have parameter DATA_W, default 16, meaning the stored magnitude width.
REQ-004 SHALL have parameter MAG_W, default 24, meaning the input magnitude width.
REQ-005 SHALL have ports: clk  in  1  sole clock (104 MHz FFT domain); one clock; reset is asynchronous and active-low, port reset_n  in  1.
REQ-006 SHALL have ports: enable  in  1  accept stream when high; s_tdata  in  MAG_W  magnitude; s_tuser  in  IDX_W  bin index; s_tlast  in  1  frame end; s_tvalid  in  1; s_tready  out  1.
REQ-007 SHALL have ports: wr_en  out  1; wr_addr  out  ADDR_W+1  {bank, bin}; wr_data  out  DATA_W  histogram BRAM write port A.
REQ-008 SHALL have ports: rd_bank  out  1  bank the display reader uses; frame_done  out  1  one-cycle pulse; frame_count  out  16  completed frames.
REQ-009 SHALL have ports: peak_bin  out  ADDR_W; peak_mag  out  DATA_W  largest bin of the last completed frame.
REQ-010 SHALL have ports: err_index, err_early_last, err_missing_last  out  1 each  one-cycle pulses.

Function
REQ-011 A beat SHALL be accepted when s_tvalid & s_tready; s_tready SHALL equal registered enable, so the block never backpressures while enabled.
REQ-012 The FSM SHALL have the states SYNC and RUN; reset SHALL enter SYNC.
REQ-013 In SYNC, accepted beats with s_tuser!=0 SHALL be discarded without writing; an accepted beat with s_tuser==0 SHALL start a frame, set expected=1, and go to RUN.
REQ-014 In RUN, an accepted beat with s_tuser!=expected SHALL pulse err_index, abort the frame (no bank swap, no peak update), and return to SYNC; the offending beat itself SHALL NOT be written.
REQ-015 In RUN, s_tlast on a beat with index<4095 SHALL pulse err_early_last and abort the frame the same way.
REQ-016 In RUN, index 4095 SHALL complete the frame; if s_tlast is low on that beat, err_missing_last SHALL pulse and the frame SHALL still complete; the FSM SHALL then return to SYNC.
REQ-017 Only beats with s_tuser[IDX_W-1:ADDR_W]==0 SHALL be written; out-of-range bins SHALL be consumed and checked only.
REQ-018 wr_data SHALL equal s_tdata[DATA_W-1:0] when s_tdata[MAG_W-1:DATA_W]==0, and otherwise all-ones (saturation).
REQ-019 Write latency: a beat accepted in cycle N SHALL produce wr_en=1 in cycle N+1, with wr_addr={~rd_bank, s_tuser[ADDR_W-1:0]}.
REQ-020 The peak tracker SHALL consider written bins 1..1023 (DC excluded) using strict greater-than, so ties keep the lowest bin; it SHALL clear at frame start.
REQ-021 When the completing beat is accepted in cycle N: frame_done SHALL pulse in N+2, rd_bank SHALL toggle in N+2, and peak_bin, peak_mag and frame_count (+1, wrapping at 65535->0) SHALL update in N+2.
REQ-022 When enable falls mid-frame, the block SHALL abort to SYNC silently, with no error pulse.
REQ-023 A frame starting in the cycle immediately after completion SHALL be accepted with no gap cycle.

Reset
REQ-024 On reset_n low, asynchronously: SYNC state; s_tready=0; wr_en=0; wr_addr=0; wr_data=0; rd_bank=0; frame_done=0; frame_count=0; peak_bin=0; peak_mag=0; all error pulses=0.
REQ-025 Reset asserted mid-frame SHALL discard the frame; after release, no write SHALL occur until a new index-0 beat arrives.

Structure
REQ-026 A shared package SHALL hold IDX_W, ADDR_W, DATA_W, MAG_W, FRAME_LEN=4096, and the FSM state encoding.
REQ-027 The peak search SHALL be a sub-module, bin_peak_tracker (clear, sample valid/bin/mag -> peak_bin/peak_mag).

Verification
REQ-028 Full frame with indices 0..4095, tlast on 4095, mag = bin*3 -> 1024 writes to bank 1; frame_done in N+2; rd_bank=1; peak_bin=1023; peak_mag=3069; frame_count=1.
REQ-029 Frame with bin 7 mag=0x012345 -> wr_data=0xFFFF at bin 7; peak_bin=7.
REQ-030 Stream starting at index 100 -> no writes until index 0; then a normal frame completes.
REQ-031 Skip index 500 -> err_index pulse; rd_bank unchanged; frame_count unchanged; the next 0..4095 frame completes normally.
REQ-032 tlast at index 2000 -> err_early_last; no swap. tlast missing at 4095 -> err_missing_last, frame_done, swap.
REQ-033 reset_n low at index 3000 -> all outputs at reset values immediately; after release, a mid-frame continuation (3001..) produces no writes.
